// File: rtl/cla_pkg.sv
// -----------------------------------------------------------------------------
// cla_pkg
// Shared constants and types for the 16-bit two-level carry-lookahead adder.
//   CLA_WIDTH : operand width (16)
//   CLA_GRP   : bits per lookahead group (4)
//   CLA_NGRP  : number of groups (4)
//   cla_word_t: operand/sum word
//   cla_pg_t  : group propagate/generate pair
// -----------------------------------------------------------------------------
package cla_pkg;

    localparam int CLA_WIDTH = 16;
    localparam int CLA_GRP   = 4;
    localparam int CLA_NGRP  = 4;

    typedef logic [CLA_WIDTH-1:0] cla_word_t;

    typedef struct packed {
        logic p;
        logic g;
    } cla_pg_t;

endpackage

// File: rtl/cla4_block.sv
// -----------------------------------------------------------------------------
// cla4_block
// Purely combinational 4-bit carry-lookahead slice. All internal carries are
// flat sum-of-products of the bit generate/propagate terms and the slice
// carry-in, so no carry ripples from bit to bit.
// Ports:
//   a, b  (in,  4) operand slices
//   ci    (in,  1) carry into bit 0 of the slice
//   s     (out, 4) sum slice
//   P     (out, 1) group propagate
//   G     (out, 1) group generate
//   c3    (out, 1) carry into the top bit of the slice (signed-overflow tap)
// -----------------------------------------------------------------------------
module cla4_block
    import cla_pkg::*;
(
    input  logic [CLA_GRP-1:0] a,
    input  logic [CLA_GRP-1:0] b,
    input  logic               ci,
    output logic [CLA_GRP-1:0] s,
    output logic               P,
    output logic               G,
    output logic               c3
);

    logic [CLA_GRP-1:0] g;
    logic [CLA_GRP-1:0] p;
    logic [CLA_GRP-1:0] c;

    assign g = a & b;
    assign p = a ^ b;

    assign c[0] = ci;
    assign c[1] = g[0] | (p[0] & ci);
    assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & ci);
    assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
                | (p[2] & p[1] & p[0] & ci);

    assign G = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
             | (p[3] & p[2] & p[1] & g[0]);
    assign P = &p;

    assign s  = p ^ c;
    assign c3 = c[3];

endmodule

// File: rtl/cla_adder16.sv
// -----------------------------------------------------------------------------
// cla_adder16
// 16-bit two-level carry-lookahead adder with registered outputs (1-cycle
// latency, one add per cycle). Four cla4_block slices produce group P/G; the
// second-level lookahead here forms C4..C16 directly from P/G and cin.
// Optional feature macro: CLA_OVF_EN adds the registered signed-overflow
// output ovf.
// Ports:
//   clk   (in,  1)  rising-edge clock
//   reset (in,  1)  synchronous active-high reset, clears all outputs
//   A, B  (in,  16) unsigned operands
//   cin   (in,  1)  carry-in
//   sum   (out, 16) registered (A + B + cin) mod 2^16
//   cout  (out, 1)  registered carry-out (bit 16)
//   ovf   (out, 1)  registered signed overflow (CLA_OVF_EN only)
// -----------------------------------------------------------------------------
module cla_adder16
    import cla_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] A,
    input  logic [15:0] B,
    input  logic        cin,
    output logic [15:0] sum,
    output logic        cout
`ifdef CLA_OVF_EN
    ,
    output logic        ovf
`endif
);

    cla_pg_t [CLA_NGRP-1:0] grp_pg;
    logic    [CLA_NGRP-1:0] gp;
    logic    [CLA_NGRP-1:0] gg;
    logic    [CLA_NGRP-1:0] grp_c3;
    logic    [CLA_NGRP:0]   gc;     // gc[k] = carry into group k, gc[4] = C16
    cla_word_t              s_w;

    cla_word_t sum_d, sum_q;
    logic      cout_d, cout_q;

    for (genvar k = 0; k < CLA_NGRP; k++) begin : g_grp
        cla4_block u_blk (
            .a  (A[k*CLA_GRP +: CLA_GRP]),
            .b  (B[k*CLA_GRP +: CLA_GRP]),
            .ci (gc[k]),
            .s  (s_w[k*CLA_GRP +: CLA_GRP]),
            .P  (grp_pg[k].p),
            .G  (grp_pg[k].g),
            .c3 (grp_c3[k])
        );
        assign gp[k] = grp_pg[k].p;
        assign gg[k] = grp_pg[k].g;
    end

    // Second-level lookahead: each group carry is a flat SOP of G/P and cin.
    assign gc[0] = cin;
    assign gc[1] = gg[0] | (gp[0] & cin);
    assign gc[2] = gg[1] | (gp[1] & gg[0]) | (gp[1] & gp[0] & cin);
    assign gc[3] = gg[2] | (gp[2] & gg[1]) | (gp[2] & gp[1] & gg[0])
                 | (gp[2] & gp[1] & gp[0] & cin);
    assign gc[4] = gg[3] | (gp[3] & gg[2]) | (gp[3] & gp[2] & gg[1])
                 | (gp[3] & gp[2] & gp[1] & gg[0])
                 | (gp[3] & gp[2] & gp[1] & gp[0] & cin);

    assign sum_d  = s_w;
    assign cout_d = gc[4];

    always_ff @(posedge clk) begin
        if (reset) begin
            sum_q  <= '0;
            cout_q <= 1'b0;
        end else begin
            sum_q  <= sum_d;
            cout_q <= cout_d;
        end
    end

    assign sum  = sum_q;
    assign cout = cout_q;

`ifdef CLA_OVF_EN
    logic ovf_d, ovf_q;
    logic unused_c3_lo;

    // Overflow when the carry into the sign bit differs from the carry out.
    assign ovf_d        = gc[4] ^ grp_c3[CLA_NGRP-1];
    assign unused_c3_lo = ^grp_c3[CLA_NGRP-2:0];

    always_ff @(posedge clk) begin
        if (reset) begin
            ovf_q <= 1'b0;
        end else begin
            ovf_q <= ovf_d;
        end
    end

    assign ovf = ovf_q;
`else
    // Slice top-bit carries only feed the overflow logic.
    logic unused_c3;
    assign unused_c3 = ^grp_c3;
`endif

endmodule

// File: tb/tb_cla_adder16.sv
// -----------------------------------------------------------------------------
// tb_cla_adder16
// Self-checking bench for cla_adder16: directed literal cases plus 10k random
// back-to-back adds with a mid-stream reset pulse, compared every cycle
// against a plain-arithmetic reference delayed by one clock.
// -----------------------------------------------------------------------------
module tb_cla_adder16;

    logic        clk;
    logic        reset;
    logic [15:0] A;
    logic [15:0] B;
    logic        cin;
    logic [15:0] sum;
    logic        cout;
`ifdef CLA_OVF_EN
    logic        ovf;
`endif

    int n_checks = 0;
    int n_pass   = 0;

    cla_adder16 dut (
        .clk   (clk),
        .reset (reset),
        .A     (A),
        .B     (B),
        .cin   (cin),
        .sum   (sum),
        .cout  (cout)
`ifdef CLA_OVF_EN
        ,
        .ovf   (ovf)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: result of the inputs seen at the previous rising edge.
    logic [15:0] exp_sum;
    logic        exp_cout;
    logic        exp_ovf;
    logic        exp_vld = 1'b0;

    always @(posedge clk) begin
        logic [16:0] full;
        full = {1'b0, A} + {1'b0, B} + {16'd0, cin};
        exp_vld <= 1'b1;
        if (reset) begin
            exp_sum  <= 16'd0;
            exp_cout <= 1'b0;
            exp_ovf  <= 1'b0;
        end else begin
            exp_sum  <= full[15:0];
            exp_cout <= full[16];
            exp_ovf  <= (A[15] == B[15]) && (full[15] != A[15]);
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act === req) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h, expected %0h at t=%0t", name, act, req, $time);
        end
    endtask

    // Model-driven compare on every cycle once outputs are defined.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (exp_vld) begin
                check("model_sum", {16'd0, sum}, {16'd0, exp_sum});
                check("model_cout", {31'd0, cout}, {31'd0, exp_cout});
`ifdef CLA_OVF_EN
                check("model_ovf", {31'd0, ovf}, {31'd0, exp_ovf});
`endif
            end
        end
    end

    // Drive one set of inputs for one edge; return after outputs settle.
    task automatic apply(input logic [15:0] a, input logic [15:0] b,
                         input logic c, input logic r);
        @(negedge clk);
        A     = a;
        B     = b;
        cin   = c;
        reset = r;
        @(posedge clk);
        #2;
    endtask

    task automatic lit(input string name, input logic [15:0] s_req, input logic c_req);
        check({name, "_sum"}, {16'd0, sum}, {16'd0, s_req});
        check({name, "_cout"}, {31'd0, cout}, {31'd0, c_req});
    endtask

    initial begin
        A = 16'hFFFF; B = 16'h0001; cin = 1'b1; reset = 1'b1;

        apply(16'hFFFF, 16'h0001, 1'b1, 1'b1);
        lit("reset", 16'h0000, 1'b0);
`ifdef CLA_OVF_EN
        check("reset_ovf", {31'd0, ovf}, 32'd0);
`endif

        apply(16'd120,   16'd100,   1'b1, 1'b0); lit("add_120_100",   16'd221,   1'b0);
        apply(16'd20,    16'd3,     1'b0, 1'b0); lit("add_20_3",      16'd23,    1'b0);
        apply(16'd300,   16'd160,   1'b1, 1'b0); lit("add_300_160",   16'd461,   1'b0);
        apply(16'd1038,  16'd1024,  1'b0, 1'b0); lit("add_1038_1024", 16'd2062,  1'b0);
        apply(16'd65534, 16'd1,     1'b0, 1'b0); lit("add_65534_1",   16'd65535, 1'b0);
        apply(16'd65535, 16'd1,     1'b0, 1'b0); lit("add_65535_1",   16'd0,     1'b1);
        apply(16'd65535, 16'd65535, 1'b1, 1'b0); lit("add_max_max",   16'd65535, 1'b1);

        apply(16'h7FFF, 16'h0001, 1'b0, 1'b0); lit("ovf_pos", 16'h8000, 1'b0);
`ifdef CLA_OVF_EN
        check("ovf_pos_ovf", {31'd0, ovf}, 32'd1);
`endif
        apply(16'h8000, 16'h8000, 1'b0, 1'b0); lit("ovf_neg", 16'h0000, 1'b1);
`ifdef CLA_OVF_EN
        check("ovf_neg_ovf", {31'd0, ovf}, 32'd1);
`endif
        apply(16'h7FFF, 16'h8000, 1'b0, 1'b0); lit("ovf_none", 16'hFFFF, 1'b0);
`ifdef CLA_OVF_EN
        check("ovf_none_ovf", {31'd0, ovf}, 32'd0);
`endif

        // Random back-to-back stream with a one-cycle reset pulse in the middle.
        for (int i = 0; i < 10000; i++) begin
            if (i == 5000) begin
                apply(16'($urandom), 16'($urandom), 1'($urandom), 1'b1);
                lit("midreset", 16'h0000, 1'b0);
`ifdef CLA_OVF_EN
                check("midreset_ovf", {31'd0, ovf}, 32'd0);
`endif
            end else begin
                apply(16'($urandom), 16'($urandom), 1'($urandom), 1'b0);
            end
        end

        @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
